// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Arbitrates N_IRQ edge-triggered interrupt request lines for the microprogram
// sequencer. Rising edges on int_req latch into pending bits. Pending lines
// that are not masked, while the global interrupt enable (IE) is set, compete
// for a single request to the sequencer. The winner's id and vector stay
// stable until int_ack. The controller then reports in_service until eoi.
//
// Optional feature macro: INT_ROUND_ROBIN_EN
//   defined   - rotating priority; the search starts at a pointer that moves
//               to (int_id+1) mod N_IRQ on every acknowledge.
//   undefined - fixed priority, index 0 highest; no pointer register.
//
// Ports
//   clk              in   system clock, rising edge
//   interrupt_reset  in   synchronous active-high reset
//   int_req          in   [N_IRQ]  request lines (rising edge = event)
//   mask_we          in   load mask from mask_wdata
//   mask_wdata       in   [N_IRQ]  new mask, 1 = enabled
//   ie_set / ie_clr  in   EI / DI (clear wins)
//   int_ack          in   sequencer took the interrupt (1-cycle pulse)
//   eoi              in   service routine returned (1-cycle pulse)
//   irq              out  request to sequencer
//   int_id           out  [clog2(N_IRQ)] winning line
//   int_vector       out  [VEC_W] routine address for int_id
//   in_service       out  routine in progress
//   pending          out  [N_IRQ] pending bits
//   mask             out  [N_IRQ] current mask
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int                N_IRQ     = 4,
  parameter int                VEC_W     = 8,
  parameter logic [VEC_W-1:0]  VEC_BASE  = VEC_W'('h10),
  parameter int                VEC_SHIFT = 2,
  parameter logic [N_IRQ-1:0]  MASK_RST  = {N_IRQ{1'b1}},
  localparam int               ID_W      = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             interrupt_reset,
  input  logic [N_IRQ-1:0] int_req,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             ie_set,
  input  logic             ie_clr,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             irq,
  output logic [ID_W-1:0]  int_id,
  output logic [VEC_W-1:0] int_vector,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [N_IRQ-1:0] req_prev;
  logic [N_IRQ-1:0] pending_r;
  logic [N_IRQ-1:0] mask_r;
  logic             ie;
  logic [ID_W-1:0]  id_r;
  logic [VEC_W-1:0] vec_r;

  logic [N_IRQ-1:0] edges;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clr;
  logic [ID_W-1:0]  search_start;
  logic [ID_W-1:0]  winner;
  logic             grant;
  logic             ack_take;
  logic             eoi_take;

  // First eligible line found when scanning upward (with wrap) from start.
  function automatic logic [ID_W-1:0] pick(input logic [N_IRQ-1:0] elig,
                                           input logic [ID_W-1:0]  start);
    logic [ID_W-1:0] r;
    logic            found;
    int              idx;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < N_IRQ; k++) begin
      idx = (int'(start) + k) % N_IRQ;
      if (!found && elig[idx[ID_W-1:0]]) begin
        r     = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] vec_of(input logic [ID_W-1:0] id);
    return VEC_BASE + (VEC_W'(id) << VEC_SHIFT);
  endfunction

  assign edges    = int_req & ~req_prev;
  assign eligible = pending_r & mask_r;
  assign winner   = pick(eligible, search_start);

`ifdef INT_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (interrupt_reset) begin
      rr_ptr <= '0;
    end else if (ack_take) begin
      rr_ptr <= (id_r == ID_W'(N_IRQ - 1)) ? '0 : id_r + ID_W'(1);
    end
  end

  assign search_start = rr_ptr;
`else
  assign search_start = '0;
`endif

  // Next-state logic. Decisions use registered IE/mask, so a mask write or
  // DI is seen by the FSM one edge after it is loaded.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ack_take  = 1'b0;
    eoi_take  = 1'b0;
    clr       = '0;
    case (state)
      IDLE: begin
        if (ie && (|eligible)) begin
          state_nxt = REQ;
          grant     = 1'b1;
        end
      end
      REQ: begin
        // eoi is meaningless here, so ack alone decides.
        if (int_ack) begin
          state_nxt   = SERVICE;
          ack_take    = 1'b1;
          clr[id_r]   = 1'b1;
        end else if (!ie || !mask_r[id_r]) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          state_nxt = IDLE;
          eoi_take  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (interrupt_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (interrupt_reset) begin
      req_prev  <= '0;
      pending_r <= '0;
      mask_r    <= MASK_RST;
      ie        <= 1'b0;
      id_r      <= '0;
      vec_r     <= VEC_BASE;
    end else begin
      req_prev  <= int_req;
      // A new edge on the line being acknowledged survives the clear.
      pending_r <= (pending_r & ~clr) | edges;
      if (mask_we) begin
        mask_r <= mask_wdata;
      end
      // Hardware ack/eoi override the EI/DI instructions.
      if (ack_take) begin
        ie <= 1'b0;
      end else if (eoi_take) begin
        ie <= 1'b1;
      end else if (ie_clr) begin
        ie <= 1'b0;
      end else if (ie_set) begin
        ie <= 1'b1;
      end
      if (grant) begin
        id_r  <= winner;
        vec_r <= vec_of(winner);
      end
    end
  end

  assign irq        = (state == REQ);
  assign in_service = (state == SERVICE);
  assign int_id     = id_r;
  assign int_vector = vec_r;
  assign pending    = pending_r;
  assign mask       = mask_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Directed scenarios followed by randomized traffic for interrupt_controller
// (N_IRQ=4, VEC_W=8, VEC_BASE=8'h10, VEC_SHIFT=2). A behavioural model of the
// controller advances on every rising edge and all outputs are compared one
// time unit later.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       interrupt_reset;
  logic [3:0] int_req;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       ie_set;
  logic       ie_clr;
  logic       int_ack;
  logic       eoi;
  logic       irq;
  logic [1:0] int_id;
  logic [7:0] int_vector;
  logic       in_service;
  logic [3:0] pending;
  logic [3:0] mask;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int         m_mode;   // 0 idle, 1 requesting, 2 in service
  int         m_id;
  int         m_rr;
  logic [3:0] m_pend;
  logic [3:0] m_prev;
  logic [3:0] m_mask;
  logic       m_ie;

  always #5 clk = ~clk;

  interrupt_controller #(.N_IRQ(4), .VEC_W(8)) dut (
    .clk             (clk),
    .interrupt_reset (interrupt_reset),
    .int_req         (int_req),
    .mask_we         (mask_we),
    .mask_wdata      (mask_wdata),
    .ie_set          (ie_set),
    .ie_clr          (ie_clr),
    .int_ack         (int_ack),
    .eoi             (eoi),
    .irq             (irq),
    .int_id          (int_id),
    .int_vector      (int_vector),
    .in_service      (in_service),
    .pending         (pending),
    .mask            (mask)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Index of the lowest set bit of a nonzero value.
  function automatic int lowest(input int v);
    return $clog2(v & -v);
  endfunction

  // Rotate the request set so that 'start' sits at bit 0, take the lowest.
  function automatic int winner(input int el, input int start);
    int rot;
    rot = ((el >> start) | (el << (N - start))) & 15;
    return (lowest(rot) + start) % N;
  endfunction

  task automatic model_edge();
    logic [3:0] edges, elig, clr;
    int nmode, nid, start;
    logic ack_t, eoi_t;
    if (interrupt_reset) begin
      m_pend = 4'h0; m_prev = 4'h0; m_mask = 4'hF; m_ie = 1'b0;
      m_mode = 0; m_id = 0; m_rr = 0;
      return;
    end
`ifdef INT_ROUND_ROBIN_EN
    start = m_rr;
`else
    start = 0;
`endif
    edges = int_req & ~m_prev;
    elig  = m_pend & m_mask;
    ack_t = (m_mode == 1) && int_ack;
    eoi_t = (m_mode == 2) && eoi;
    nmode = m_mode;
    nid   = m_id;
    clr   = 4'h0;
    case (m_mode)
      0: if (m_ie && elig != 4'h0) begin
           nmode = 1;
           nid   = winner(int'(elig), start);
         end
      1: if (ack_t) begin
           nmode = 2;
           clr   = 4'(1 << m_id);
         end else if (!m_ie || !m_mask[m_id[1:0]]) begin
           nmode = 0;
         end
      2: if (eoi_t) nmode = 0;
      default: nmode = 0;
    endcase
    m_pend = (m_pend & ~clr) | edges;
    if (ack_t)       m_ie = 1'b0;
    else if (eoi_t)  m_ie = 1'b1;
    else if (ie_clr) m_ie = 1'b0;
    else if (ie_set) m_ie = 1'b1;
    if (ack_t) m_rr = (m_id + 1) % N;
    if (mask_we) m_mask = mask_wdata;
    m_prev = int_req;
    m_mode = nmode;
    m_id   = nid;
  endtask

  task automatic compare_all();
    chk("irq",        32'(irq),        32'(m_mode == 1));
    chk("in_service", 32'(in_service), 32'(m_mode == 2));
    chk("int_id",     32'(int_id),     32'(m_id));
    chk("int_vector", 32'(int_vector), 32'((16 + 4 * m_id) & 255));
    chk("pending",    32'(pending),    32'(m_pend));
    chk("mask",       32'(mask),       32'(m_mask));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  int seen;
  int t;

  initial begin
    interrupt_reset = 1'b1;
    int_req = 4'h0; mask_we = 1'b0; mask_wdata = 4'h0;
    ie_set = 1'b0; ie_clr = 1'b0; int_ack = 1'b0; eoi = 1'b0;
    step();
    step();
    chk("rst_vector", 32'(int_vector), 32'h10);
    chk("rst_mask",   32'(mask),       32'hF);
    interrupt_reset = 1'b0;

    // 1: pending latches with IE=0; EI lets it through two edges later
    int_req = 4'b0100; step();
    int_req = 4'b0000; step();
    chk("t1_pending", 32'(pending), 32'h4);
    chk("t1_noirq",   32'(irq),     32'h0);
    ie_set = 1'b1; step();
    ie_set = 1'b0;
    chk("t1_irq_early", 32'(irq), 32'h0);
    step();
    chk("t1_irq", 32'(irq),        32'h1);
    chk("t1_id",  32'(int_id),     32'h2);
    chk("t1_vec", 32'(int_vector), 32'h18);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;

    // 2: simultaneous edges, lowest wins; second served after eoi
    int_req = 4'b1010; step();
    int_req = 4'b0000; step();
    chk("t2_id",  32'(int_id),     32'h1);
    chk("t2_vec", 32'(int_vector), 32'h14);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("t2_pending", 32'(pending),    32'h8);
    chk("t2_insvc",   32'(in_service), 32'h1);
    eoi = 1'b1; step(); eoi = 1'b0;
    step();
    chk("t2_irq3", 32'(irq),        32'h1);
    chk("t2_vec3", 32'(int_vector), 32'h1C);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;

    // 3: masking the active line withdraws irq but keeps pending
    int_req = 4'b0001; step();
    int_req = 4'b0000; step();
    mask_we = 1'b1; mask_wdata = 4'b1110; step();
    mask_we = 1'b0; step();
    chk("t3_irq_drop", 32'(irq),     32'h0);
    chk("t3_pending",  32'(pending), 32'h1);
    mask_we = 1'b1; mask_wdata = 4'b1111; step();
    mask_we = 1'b0; step();
    chk("t3_irq_back", 32'(irq), 32'h1);

    // 4: ack and a new edge on the same line in one cycle
    int_req = 4'b0001; int_ack = 1'b1; step();
    int_req = 4'b0000; int_ack = 1'b0;
    chk("t4_pending", 32'(pending),    32'h1);
    chk("t4_insvc",   32'(in_service), 32'h1);

    // 5: stray pulses, then reset from SERVICE
    int_ack = 1'b1; step(); int_ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("t5_idle_ack_pend", 32'(pending), 32'h1);
    eoi = 1'b1; step(); eoi = 1'b0;
    chk("t5_req_eoi_irq", 32'(irq), 32'h1);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    interrupt_reset = 1'b1; step(); interrupt_reset = 1'b0;
    chk("t5_rst_insvc", 32'(in_service), 32'h0);
    chk("t5_rst_vec",   32'(int_vector), 32'h10);

    // 6: lines 0 and 1 kept pending
    ie_set = 1'b1; step(); ie_set = 1'b0;
    int_req = 4'b0011; step(); int_req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!irq && t < 20) begin step(); t++; end
      chk("t6_irq", 32'(irq), 32'h1);
      seen = int'(int_id);
`ifdef INT_ROUND_ROBIN_EN
      chk("t6_order", 32'(seen), 32'(i % 2));
`else
      chk("t6_order", 32'(seen), 32'h0);
`endif
      int_ack = 1'b1; step(); int_ack = 1'b0;
      int_req = 4'(1 << seen); step(); int_req = 4'b0000;
      eoi = 1'b1; step(); eoi = 1'b0;
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) int_req = 4'($urandom);
      mask_we         = ($urandom_range(0, 15) == 0);
      mask_wdata      = 4'($urandom);
      ie_set          = ($urandom_range(0, 5) == 0);
      ie_clr          = ($urandom_range(0, 15) == 0);
      int_ack         = ($urandom_range(0, 2) == 0);
      eoi             = ($urandom_range(0, 3) == 0);
      interrupt_reset = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
